// File: rtl/even_sweep_ctrl_pkg.sv
// rtl/even_sweep_ctrl_pkg.sv - shared state encoding and step size for the even sweep controller
package even_sweep_ctrl_pkg;

    localparam int STEP = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_e;

endpackage

// File: rtl/even_sweep_ctrl_if.sv
// rtl/even_sweep_ctrl_if.sv - run request, bounds and status bundle of the even sweep controller
interface even_sweep_ctrl_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic         start;
    logic         abort;
    logic [N-1:0] lo;
    logic [N-1:0] hi;
    logic [W-1:0] dwell;
    logic [W-1:0] sweeps;
    logic [N-1:0] q;
    logic         busy;
    logic         up;
    logic         done;
    logic         err;
    logic         aborted;

    modport master (
        output start, abort, lo, hi, dwell, sweeps,
        input  q, busy, up, done, err, aborted
    );

    modport slave (
        input  start, abort, lo, hi, dwell, sweeps,
        output q, busy, up, done, err, aborted
    );
endinterface

// File: rtl/even_sweep_ctrl_step_counter.sv
// rtl/even_sweep_ctrl_step_counter.sv - N-bit loadable counter stepping by two in either direction
module even_step_counter
    import even_sweep_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         en_i,
    input  logic         up_i,
    output logic [N-1:0] q_o
);
    logic [N-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= load_val_i;
        end else if (en_i) begin
            q_q <= up_i ? q_q + N'(STEP) : q_q - N'(STEP);
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/even_sweep_ctrl.sv
// rtl/even_sweep_ctrl.sv - sweeps an even count between latched bounds with endpoint dwell and abort
module even_sweep_ctrl
    import even_sweep_ctrl_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    even_sweep_ctrl_if.slave bus
);
    state_e       state_q;
    logic [N-1:0] lo_q, hi_q, cnt_val;
    logic [W-1:0] dwell_q, sweeps_q, hold_q, sweep_cnt_q;
    logic         busy_q, up_q, done_q, err_q, aborted_q;

    logic [N-1:0] lo_e, hi_e;
    logic [W-1:0] sweep_cnt_d, sweeps_eff;
    logic         start_ok, cnt_en, rise_hit, fall_hit;

    assign lo_e        = {bus.lo[N-1:1], 1'b0};
    assign hi_e        = {bus.hi[N-1:1], 1'b0};
    assign start_ok    = (state_q == ST_IDLE) && bus.start && !bus.abort && (lo_e < hi_e);
    assign cnt_en      = ((state_q == ST_RISE) || (state_q == ST_FALL)) && !bus.abort;
    assign rise_hit    = (cnt_val + N'(STEP)) == hi_q;
    assign fall_hit    = (cnt_val - N'(STEP)) == lo_q;
    assign sweep_cnt_d = sweep_cnt_q + W'(1);
    assign sweeps_eff  = (sweeps_q == '0) ? W'(1) : sweeps_q;

    even_step_counter #(.N(N)) u_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (start_ok),
        .load_val_i (lo_e),
        .en_i       (cnt_en),
        .up_i       (state_q == ST_RISE),
        .q_o        (cnt_val)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= '0;
            sweeps_q    <= '0;
            hold_q      <= '0;
            sweep_cnt_q <= '0;
            busy_q      <= 1'b0;
            up_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                // Abort masks Start entirely, including the bad-bounds error
                if (start_ok) begin
                    lo_q        <= lo_e;
                    hi_q        <= hi_e;
                    dwell_q     <= bus.dwell;
                    sweeps_q    <= bus.sweeps;
                    sweep_cnt_q <= '0;
                    state_q     <= ST_RISE;
                    busy_q      <= 1'b1;
                    up_q        <= 1'b1;
                end else if (bus.start && !bus.abort) begin
                    err_q <= 1'b1;
                end
            end else if (bus.abort) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                up_q      <= 1'b0;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_RISE: begin
                        if (rise_hit) begin
                            state_q <= ST_HOLD_HI;
                            hold_q  <= '0;
                        end
                    end
                    ST_HOLD_HI: begin
                        if (hold_q == dwell_q) begin
                            state_q <= ST_FALL;
                            up_q    <= 1'b0;
                        end else begin
                            hold_q <= hold_q + W'(1);
                        end
                    end
                    ST_FALL: begin
                        if (fall_hit) begin
                            state_q <= ST_HOLD_LO;
                            hold_q  <= '0;
                        end
                    end
                    ST_HOLD_LO: begin
                        if (hold_q != dwell_q) begin
                            hold_q <= hold_q + W'(1);
                        end else if (sweep_cnt_d == sweeps_eff) begin
                            state_q     <= ST_IDLE;
                            sweep_cnt_q <= sweep_cnt_d;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q     <= ST_RISE;
                            sweep_cnt_q <= sweep_cnt_d;
                            up_q        <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.q       = cnt_val;
    assign bus.busy    = busy_q;
    assign bus.up      = up_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.aborted = aborted_q;
endmodule

// File: tb/tb_even_sweep_ctrl.sv
// tb/tb_even_sweep_ctrl.sv - randomized and directed checks of even_sweep_ctrl against a trajectory model
module tb_even_sweep_ctrl;
    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    even_sweep_ctrl_if #(.N(N), .W(W)) bus ();

    even_sweep_ctrl #(.N(N), .W(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int model_q = 0;
    int exp_q[$];
    bit exp_up[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int q, input bit busy, input bit up,
                           input bit done, input bit err, input bit ab);
        check_val({tag, ".q"}, 32'(bus.q), q);
        check_val({tag, ".busy"}, 32'(bus.busy), 32'(busy));
        check_val({tag, ".up"}, 32'(bus.up), 32'(up));
        check_val({tag, ".done"}, 32'(bus.done), 32'(done));
        check_val({tag, ".err"}, 32'(bus.err), 32'(err));
        check_val({tag, ".aborted"}, 32'(bus.aborted), 32'(ab));
    endtask

    // Expected (Q, Up) seen after each edge following the accepting edge of a run.
    task automatic build(input int lo, input int hi, input int d, input int s);
        int ns;
        exp_q.delete();
        exp_up.delete();
        ns = (s == 0) ? 1 : s;
        for (int k = 0; k < ns; k++) begin
            for (int v = (k == 0) ? lo : lo + 2; v <= hi; v += 2) begin
                exp_q.push_back(v); exp_up.push_back(1'b1);
            end
            for (int i = 0; i <= d; i++) begin
                exp_q.push_back(hi); exp_up.push_back(i < d);
            end
            for (int v = hi - 2; v >= lo; v -= 2) begin
                exp_q.push_back(v); exp_up.push_back(1'b0);
            end
            for (int i = 0; i <= d; i++) begin
                exp_q.push_back(lo); exp_up.push_back((i == d) && (k < ns - 1));
            end
        end
    endtask

    task automatic scramble(input bit noise);
        bus.lo     = N'($urandom);
        bus.hi     = N'($urandom);
        bus.dwell  = W'($urandom);
        bus.sweeps = W'($urandom);
        bus.start  = noise ? 1'($urandom) : 1'b0;
    endtask

    task automatic run_case(input int lo, input int hi, input int d, input int s,
                            input int abort_at, input int reset_at, input bit noise);
        bit last;
        build(lo & ~1, hi & ~1, d, s);
        bus.lo = N'(lo); bus.hi = N'(hi); bus.dwell = W'(d); bus.sweeps = W'(s);
        bus.abort = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        for (int j = 0; j < exp_q.size(); j++) begin
            last = (j == exp_q.size() - 1);
            chk_out("run", exp_q[j], !last, exp_up[j], last, 1'b0, 1'b0);
            model_q = exp_q[j];
            if (last) break;
            scramble(noise);
            if (j == abort_at) begin
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0; bus.start = 1'b0;
                chk_out("abort", model_q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
            if (j == reset_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1; bus.start = 1'b0;
                model_q = 0;
                chk_out("midreset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk_out("post", model_q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic bad_start(input int lo, input int hi);
        bus.lo = N'(lo); bus.hi = N'(hi); bus.abort = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk_out("badstart", model_q, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("badstart_after", model_q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_with_abort();
        bus.lo = 4'd2; bus.hi = 4'd10; bus.dwell = '0; bus.sweeps = 4'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk_out("start_abort_idle", model_q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("start_abort_after", model_q, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lo, hi;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.lo = '0; bus.hi = '0; bus.dwell = '0; bus.sweeps = '0;
        rst_n = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_out("reset_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_case(2, 8, 0, 1, -1, -1, 1'b0);
        bad_start(4, 4);
        bad_start(6, 3);
        bad_start(5, 4);
        run_case(0, 14, 2, 2, -1, -1, 1'b1);
        run_case(2, 14, 0, 1, 2, -1, 1'b0);
        start_with_abort();
        run_case(0, 14, 1, 1, -1, 11, 0);
        run_case(3, 9, 1, 3, -1, -1, 1'b1);
        run_case(2, 6, 0, 1, 5, -1, 1'b0);
        run_case(12, 14, 0, 0, -1, -1, 1'b0);

        for (int r = 0; r < 30; r++) begin
            lo = int'($urandom_range(0, 15));
            hi = int'($urandom_range(0, 15));
            if ((lo & ~1) >= (hi & ~1)) begin
                bad_start(lo, hi);
            end else begin
                run_case(lo, hi, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1,
                         -1, 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
